// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed 7-segment scan controller.
// Holds a shadow/active pair of display sets so that a new value only
// takes effect at a frame boundary, which keeps a frame from tearing.
// Every slot opens with a short anode-off guard to suppress ghosting.
module seg_scan_ctrl #(
    parameter int DIV   = 1000,
    parameter int GUARD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  bcd_out,
    output logic        dp_n,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame
);

    localparam int PW = $clog2(DIV);

    // One complete display set: four BCD nibbles, the decimal points and
    // the leading-zero blanking enable.
    typedef struct packed {
        logic [3:0][3:0] dig;
        logic [3:0]      dp;
        logic            blank;
    } disp_t;

    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic          tick;
    logic          guard;
    disp_t         load_set;
    disp_t         shadow;
    disp_t         active;
    logic [3:0]    lz;
    logic [3:0]    nib;

    assign load_set = {digits_in, dp_in, blank_lz};
    assign tick     = (pre == PW'(DIV - 1));
    assign frame    = tick && (idx == 2'd3);
    assign guard    = (pre < PW'(GUARD));

    // Scan counters, shadow capture and frame-boundary commit.
    // At a boundary a same-cycle load goes straight to active, because it
    // supersedes anything that was still waiting in the shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre     <= '0;
            idx     <= '0;
            pending <= 1'b0;
            shadow  <= '0;
            active  <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                idx <= idx + 2'd1;
            if (load)
                shadow <= load_set;
            if (frame) begin
                if (load)
                    active <= load_set;
                else if (pending)
                    active <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Leading-zero blanking chain: a digit is blanked only if it and every
    // more significant digit are zero; digit 0 always shows.
    always_comb begin
        lz    = 4'b0000;
        lz[3] = active.blank && (active.dig[3] == 4'd0);
        lz[2] = lz[3] && (active.dig[2] == 4'd0);
        lz[1] = lz[2] && (active.dig[1] == 4'd0);
    end

    // Display drive straight from registered state; all-off during guard,
    // and nibbles above 9 or blanked digits are sent as the off code.
    always_comb begin
        an      = 4'b1111;
        bcd_out = 4'b1111;
        dp_n    = 1'b1;
        nib     = active.dig[idx];
        if (!guard) begin
            an      = ~(4'b0001 << idx);
            bcd_out = (lz[idx] || (nib > 4'd9)) ? 4'b1111 : nib;
            dp_n    = ~active.dp[idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed, table-driven bench for seg_scan_ctrl at
// DIV=8, GUARD=2 (8-cycle slots, 32-cycle frames).
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  bcd_out;
    logic        dp_n;
    logic [3:0]  an;
    logic        pending;
    logic        frame;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;   // bench model of the scan position: idx*8 + pre

    seg_scan_ctrl #(.DIV(8), .GUARD(2)) dut (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .bcd_out(bcd_out),
        .dp_n(dp_n), .an(an), .pending(pending), .frame(frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic            blz;
        logic [3:0][3:0] eb;   // expected bcd_out per digit (outside guard)
        logic [3:0]      ed;   // expected dp_n per digit
    } vec_t;

    vec_t vecs[7];

    task automatic tick1();
        @(posedge clk);
        #1;
        pos = (pos + 1) % 32;
    endtask

    task automatic chk1(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s pos=%0d got=%h expected=%h", name, pos, got, exp);
        end
    endtask

    // Check n consecutive cycles of display output against a per-digit expectation.
    task automatic check_cycles(input logic [3:0][3:0] eb, input logic [3:0] ed,
                                input int n, input string name);
        for (int k = 0; k < n; k++) begin
            int p;
            int ix;
            logic [3:0] e_an;
            logic [3:0] e_bcd;
            logic       e_dpn;
            logic       e_fr;
            p  = pos % 8;
            ix = pos / 8;
            if (p < 2) begin
                e_an = 4'hF; e_bcd = 4'hF; e_dpn = 1'b1;
            end else begin
                e_an = ~(4'b0001 << ix); e_bcd = eb[ix]; e_dpn = ed[ix];
            end
            e_fr = (pos == 31);
            chk1(name, {20'd0, an, bcd_out, 3'd0, dp_n, 3'd0, frame},
                       {20'd0, e_an, e_bcd, 3'd0, e_dpn, 3'd0, e_fr});
            tick1();
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic b);
        digits_in = d; dp_in = p; blank_lz = b; load = 1'b1;
        tick1();
        load = 1'b0;
    endtask

    task automatic check_reset(input string name);
        chk1(name, {24'd0, an, bcd_out}, {24'd0, 8'hFF});
        chk1({name, "_misc"}, {29'd0, dp_n, frame, pending}, {29'd0, 3'b100});
    endtask

    logic [3:0][3:0] zb, pb, b1, b2, b5;
    logic [3:0]      pd;

    initial begin
        //               digits    dp       blz   expected bcd [3],[2],[1],[0]       dp_n
        vecs[0] = '{16'h1234, 4'b0100, 1'b0, {4'h1, 4'h2, 4'h3, 4'h4}, 4'b1011};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1, {4'hF, 4'hF, 4'h7, 4'h0}, 4'b1111};
        vecs[2] = '{16'hAB09, 4'b0000, 1'b0, {4'hF, 4'hF, 4'h0, 4'h9}, 4'b1111};
        vecs[3] = '{16'h0000, 4'b0001, 1'b1, {4'hF, 4'hF, 4'hF, 4'h0}, 4'b1110};
        vecs[4] = '{16'h0005, 4'b0000, 1'b0, {4'h0, 4'h0, 4'h0, 4'h5}, 4'b1111};
        vecs[5] = '{16'h0100, 4'b1000, 1'b1, {4'hF, 4'h1, 4'h0, 4'h0}, 4'b0111};
        vecs[6] = '{16'hFFFF, 4'b1111, 1'b1, {4'hF, 4'hF, 4'hF, 4'hF}, 4'b0000};
        zb = '0;
        b1 = {4'h1, 4'h1, 4'h1, 4'h1};
        b2 = {4'h2, 4'h2, 4'h2, 4'h2};
        b5 = {4'h5, 4'h5, 4'h5, 4'h5};

        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_lz = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        pos = 0;
        check_reset("reset");
        rst = 1'b0;

        // Idle scan after reset shows zeros with no decimal point.
        check_cycles(zb, 4'b1111, 32, "idle_frame");
        pb = zb; pd = 4'b1111;

        // Table: mid-frame load, old set holds until boundary, new set next frame.
        for (int v = 0; v < 7; v++) begin
            check_cycles(pb, pd, 5, "pre_load");
            do_load(vecs[v].digits, vecs[v].dp, vecs[v].blz);
            chk1("pending_set", {31'd0, pending}, 32'd1);
            check_cycles(pb, pd, 26, "no_tear");
            chk1("pending_clr", {31'd0, pending}, 32'd0);
            check_cycles(vecs[v].eb, vecs[v].ed, 32, "vec_frame");
            pb = vecs[v].eb; pd = vecs[v].ed;
        end

        // Last load before commit wins.
        check_cycles(pb, pd, 3, "ow_pre");
        do_load(16'h1111, 4'b0000, 1'b0);
        check_cycles(pb, pd, 6, "ow_mid");
        do_load(16'h2222, 4'b0000, 1'b0);
        chk1("ow_pending", {31'd0, pending}, 32'd1);
        check_cycles(pb, pd, 21, "ow_hold");
        check_cycles(b2, 4'b1111, 31, "ow_frame");
        // Load on the boundary cycle commits directly.
        chk1("bnd_frame", {31'd0, frame}, 32'd1);
        do_load(16'h5555, 4'b0000, 1'b0);
        chk1("bnd_pending", {31'd0, pending}, 32'd0);
        check_cycles(b5, 4'b1111, 32, "bnd_frame5");

        // Reset in digit 2 slot with data pending, and a load on the reset edge.
        check_cycles(b5, 4'b1111, 5, "rst_pre");
        do_load(16'h1234, 4'b0100, 1'b0);
        check_cycles(b5, 4'b1111, 26, "rst_old");
        check_cycles(vecs[0].eb, vecs[0].ed, 20, "rst_cur");
        do_load(16'h9999, 4'b0000, 1'b0);
        chk1("rst_pend_before", {31'd0, pending}, 32'd1);
        rst = 1'b1; load = 1'b1; digits_in = 16'h8888;
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
        pos = 0;
        check_reset("mid_reset");
        check_cycles(zb, 4'b1111, 64, "post_reset");
        if (b1 == zb) $display("note: unused pattern");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
